// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, addresses the combinational instruction memory and
// registers the returned word into IF/ID, with stall, redirect/flush and halt.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Stall,
  input  logic        i_Redirect,
  input  logic [31:0] i_Target,
  input  logic [31:0] i_Instruction,
  output logic [31:0] o_Addr,
  output logic [31:0] o_PC,
  output logic [31:0] o_PC_Plus4,
  output logic [31:0] o_Instruction,
  output logic        o_Valid,
  output logic        o_Halted,
  output logic [31:0] o_Fetch_Count
);

  // The memory answers this address with the halt word, so INIT fetches nothing useful.
  localparam logic [31:0] INIT_PC = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_HALT
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] redirect_pc;
  logic        is_halt_word;

  // Target is always word aligned; the low bits are deliberately dropped.
  assign redirect_pc  = {i_Target[31:2], 2'b00};
  assign is_halt_word = (i_Instruction[31:26] == HALT_OPCODE);
  assign o_Addr       = pc;

  logic unused_target_bits;
  assign unused_target_bits = &{1'b0, i_Target[1:0]};

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; the reset branch restores every register in the block.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state         <= ST_INIT;
      pc            <= INIT_PC;
      o_PC          <= '0;
      o_PC_Plus4    <= '0;
      o_Instruction <= '0;
      o_Valid       <= 1'b0;
      o_Halted      <= 1'b0;
      o_Fetch_Count <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          pc    <= RESET_PC;
          state <= ST_RUN;
        end

        ST_RUN: begin
          if (i_Redirect) begin
            pc            <= redirect_pc;
            o_Valid       <= 1'b0;
            o_Instruction <= '0;
          end else if (!i_Stall) begin
            o_PC          <= pc;
            o_PC_Plus4    <= pc + 32'd4;
            o_Instruction <= i_Instruction;
            o_Valid       <= 1'b1;
            if (o_Fetch_Count != 32'hFFFF_FFFF)
              o_Fetch_Count <= o_Fetch_Count + 32'd1;
            // The halt word itself still reaches decode; only the PC freezes.
            if (is_halt_word) begin
              state    <= ST_HALT;
              o_Halted <= 1'b1;
            end else begin
              pc <= pc + 32'd4;
            end
          end
        end

        ST_HALT: begin
          if (i_Redirect) begin
            pc            <= redirect_pc;
            o_Valid       <= 1'b0;
            o_Instruction <= '0;
            o_Halted      <= 1'b0;
            state         <= ST_RUN;
          end else if (!i_Stall) begin
            o_Valid <= 1'b0;
          end
        end

        default: begin
          state <= ST_INIT;
          pc    <= INIT_PC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a small memory model answers o_Addr
// combinationally; every expected value is hand-computed in the vectors below.
module tb_instruction_fetch_unit;

  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] instr;
  logic [31:0] addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr_q;
  logic        valid;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] mem [32];

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  // Out-of-range addresses (including the init address) return the fill word.
  always_comb begin
    instr = HALT_WORD;
    if (addr < 32'd128) instr = mem[addr[6:2]];
  end

  instruction_fetch_unit dut (
    .i_Clk         (clk),
    .i_Rst_n       (rst_n),
    .i_Stall       (stall),
    .i_Redirect    (redirect),
    .i_Target      (target),
    .i_Instruction (instr),
    .o_Addr        (addr),
    .o_PC          (pc),
    .o_PC_Plus4    (pc_plus4),
    .o_Instruction (instr_q),
    .o_Valid       (valid),
    .o_Halted      (halted),
    .o_Fetch_Count (fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] e_addr, input logic [31:0] e_pc,
                            input logic [31:0] e_instr, input logic e_valid,
                            input logic e_halted, input logic [31:0] e_count);
    check({tag, ".addr"},   addr,        e_addr);
    check({tag, ".pc"},     pc,          e_pc);
    check({tag, ".plus4"},  pc_plus4,    (e_pc == 32'd0 && !e_valid && e_instr == 32'd0 && e_count == 32'd0)
                                         ? 32'd0 : e_pc + 32'd4);
    check({tag, ".instr"},  instr_q,     e_instr);
    check({tag, ".valid"},  {31'd0, valid},  {31'd0, e_valid});
    check({tag, ".halted"}, {31'd0, halted}, {31'd0, e_halted});
    check({tag, ".count"},  fetch_count, e_count);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; target = '0;

    // ---------------- Phase 1: straight-line run into halt ----------------
    for (int i = 0; i < 32; i++) mem[i] = HALT_WORD;
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;
    mem[2] = HALT_WORD;
    mem[8] = 32'h240A_0020;

    tick();
    tick();
    check_ifid("reset", 32'hFFFF_FFFC, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);

    rst_n = 1'b1;
    tick();
    check_ifid("edge1", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    tick();
    check_ifid("edge2", 32'd4, 32'd0, 32'h2008_0001, 1'b1, 1'b0, 32'd1);
    tick();
    check_ifid("edge3", 32'd8, 32'd4, 32'h2009_0002, 1'b1, 1'b0, 32'd2);
    tick();
    check_ifid("edge4_halt", 32'd8, 32'd8, HALT_WORD, 1'b1, 1'b1, 32'd3);
    tick();
    check_ifid("edge5_bubble", 32'd8, 32'd8, HALT_WORD, 1'b0, 1'b1, 32'd3);

    // Speculative halt: redirect out of HALT to 0x20.
    redirect = 1'b1; target = 32'h0000_0020;
    tick();
    check_ifid("halt_redirect", 32'h20, 32'd8, 32'd0, 1'b0, 1'b0, 32'd3);
    redirect = 1'b0;
    tick();
    check_ifid("after_halt_redir", 32'h24, 32'h20, 32'h240A_0020, 1'b1, 1'b0, 32'd4);

    // ---------------- Phase 2: stall, redirects, reset mid-stall ----------------
    for (int i = 0; i < 32; i++) mem[i] = 32'h2000_0000 + 32'(i);
    rst_n = 1'b0;
    tick();
    check_ifid("reset2", 32'hFFFF_FFFC, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    rst_n = 1'b1;
    // Redirect is ignored while in INIT.
    redirect = 1'b1; target = 32'h0000_0040;
    tick();
    check_ifid("init_ignores", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    redirect = 1'b0;
    tick();
    tick();
    check_ifid("run_pc8", 32'd8, 32'd4, 32'h2000_0001, 1'b1, 1'b0, 32'd2);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_ifid("stall", 32'd8, 32'd4, 32'h2000_0001, 1'b1, 1'b0, 32'd2);
    end
    stall = 1'b0;
    tick();
    check_ifid("stall_release", 32'h0C, 32'd8, 32'h2000_0002, 1'b1, 1'b0, 32'd3);

    redirect = 1'b1; target = 32'h0000_0004;
    tick();
    check_ifid("redir_to4", 32'h04, 32'd8, 32'd0, 1'b0, 1'b0, 32'd3);
    target = 32'h0000_0043;
    tick();
    check_ifid("redir_0x43", 32'h40, 32'd8, 32'd0, 1'b0, 1'b0, 32'd3);
    redirect = 1'b0;
    tick();
    check_ifid("target_capture", 32'h44, 32'h40, 32'h2000_0010, 1'b1, 1'b0, 32'd4);

    stall = 1'b1; redirect = 1'b1; target = 32'h0000_0010;
    tick();
    check_ifid("stall_and_redir", 32'h10, 32'h40, 32'd0, 1'b0, 1'b0, 32'd4);
    stall = 1'b0; redirect = 1'b0;
    tick();
    check_ifid("after_sr", 32'h14, 32'h10, 32'h2000_0004, 1'b1, 1'b0, 32'd5);

    for (int i = 0; i < 7; i++) tick();
    check_ifid("run_to_0x30", 32'h30, 32'h2C, 32'h2000_000B, 1'b1, 1'b0, 32'd12);

    stall = 1'b1;
    tick();
    tick();
    check_ifid("stall_0x30", 32'h30, 32'h2C, 32'h2000_000B, 1'b1, 1'b0, 32'd12);
    rst_n = 1'b0;
    tick();
    check_ifid("reset_mid_stall", 32'hFFFF_FFFC, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    rst_n = 1'b1;
    tick();
    check_ifid("post_reset", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
